// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register map, bus widths, source limit.
// No logic; imported by the interface, the top and the priority encoder.
package irq_aggregator_pkg;

  localparam int N_SRC_MAX = 16;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 3;
  localparam int IDX_W     = 4;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_PENDING  = 3'd0,
    ADDR_MASK     = 3'd1,
    ADDR_EDGE_SEL = 3'd2,
    ADDR_ACTIVE   = 3'd3,
    ADDR_VECTOR   = 3'd4,
    ADDR_RAW      = 3'd5,
    ADDR_SWTRIG   = 3'd6,
    ADDR_RSVD     = 3'd7
  } reg_addr_e;

  // VECTOR word: summary flag in the top bit, winning source index in the low nibble
  function automatic logic [DATA_W-1:0] vector_word(input logic vld, input logic [IDX_W-1:0] idx);
    return {vld, 11'd0, idx};
  endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave bus of the interrupt aggregator; readdata returns one cycle after address.
interface irq_aggregator_if;
  import irq_aggregator_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/irq_aggregator_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
// Purely combinational; vld is high when any request bit is set.
module irq_prio_enc
  import irq_aggregator_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan downwards so the lowest set bit is the last assignment
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source sync + level/edge capture, mask, priority vector, Avalon-MM regs.
// Source edge to PENDING takes 2 edges after capture, irq one more; readdata is 1-cycle registered.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_aggregator_if.slave    bus,
  input  logic [N_SRC-1:0]   irq_in,
  output logic               irq
);

  logic [N_SRC-1:0]  sync1, sync2, prev, seen_low;
  logic [N_SRC-1:0]  pending, pending_next, mask, edge_sel, edge_next;
  logic [N_SRC-1:0]  wdat, w1c, sw_set, det, to_edge, active;
  logic [DATA_W-1:0] wdata_unused_hi;
  logic [DATA_W-1:0] rd_mux, readdata_q;
  logic [IDX_W-1:0]  vec_idx;
  logic              vec_vld;
  logic [1:0]        warm_cnt;
  logic              warm, wr;
  reg_addr_e         addr;

  assign addr            = reg_addr_e'(bus.address);
  assign wr              = bus.chipselect & ~bus.write_n;
  assign wdata_unused_hi = bus.writedata;
  assign wdat            = wdata_unused_hi[N_SRC-1:0];

  assign w1c       = (wr && addr == ADDR_PENDING) ? wdat : '0;
  assign sw_set    = (wr && addr == ADDR_SWTRIG)  ? wdat : '0;
  assign edge_next = (wr && addr == ADDR_EDGE_SEL) ? wdat : edge_sel;
  assign to_edge   = edge_next & ~edge_sel;

  // A source high across reset release must first be seen low before an edge counts;
  // sync2 only reflects the pin once the two synchronizer stages have refilled.
  assign warm = (warm_cnt == 2'd2);
  assign det  = sync2 & ~prev & seen_low;

  // Set (edge or SWTRIG) beats W1C; a fresh level->edge switch clears and rearms
  assign pending_next = ~to_edge &
                        ((edge_sel & ((pending & ~w1c) | det | sw_set)) |
                         (~edge_sel & sync2));

  assign active = pending & mask;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (active),
    .idx (vec_idx),
    .vld (vec_vld)
  );

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_PENDING:  rd_mux = DATA_W'(pending);
      ADDR_MASK:     rd_mux = DATA_W'(mask);
      ADDR_EDGE_SEL: rd_mux = DATA_W'(edge_sel);
      ADDR_ACTIVE:   rd_mux = DATA_W'(active);
      ADDR_VECTOR:   rd_mux = vector_word(vec_vld, vec_idx);
      ADDR_RAW:      rd_mux = DATA_W'(sync2);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      seen_low   <= '0;
      warm_cnt   <= '0;
      pending    <= '0;
      mask       <= '0;
      edge_sel   <= '0;
      readdata_q <= '0;
      irq        <= 1'b0;
    end else begin
      sync1      <= irq_in;
      sync2      <= sync1;
      prev       <= sync2;
      seen_low   <= seen_low | ({N_SRC{warm}} & ~sync2);
      if (!warm) warm_cnt <= warm_cnt + 2'd1;
      pending    <= pending_next;
      if (wr && addr == ADDR_MASK) mask <= wdat;
      edge_sel   <= edge_next;
      readdata_q <= rd_mux;
      irq        <= |active;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: doc/irq_aggregator.md
IRQ_AGGREGATOR -- requirements
Module: irq_aggregator

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources, legal range 1..16.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 address  in  3  Avalon-MM word address.
REQ-005 chipselect  in  1  slave select.
REQ-006 write_n  in  1  active-low write strobe.
REQ-007 writedata  in  16  write data.
REQ-008 readdata  out  16  registered read data.
REQ-009 irq_in  in  N_SRC  asynchronous source interrupts, e.g. timer irq lines.
REQ-010 irq  out  1  registered aggregated interrupt to the processor.

Function
REQ-011 Each irq_in bit SHALL pass through a two-flop synchronizer, followed by a third "prev" flop.
REQ-012 Register map SHALL be: 0 PENDING (R, W1C), 1 MASK (RW), 2 EDGE_SEL (RW, 1=rising edge, 0=level), 3 ACTIVE (R, PENDING&MASK), 4 VECTOR (R), 5 RAW (R, synchronized inputs), 6 SWTRIG (W, write-1-to-set), 7 reads 0.
REQ-013 Write strobe SHALL be chipselect && ~write_n; writes SHALL take effect on the same clock edge.
REQ-014 readdata SHALL register the read mux every cycle, giving 1-cycle read latency; bits at and above N_SRC SHALL read 0.
REQ-015 Level source: the PENDING bit SHALL equal the synchronized level each cycle; W1C and SWTRIG SHALL have no effect.
REQ-016 Edge source: the PENDING bit SHALL set when sync2=1 and prev=1'b0, and SHALL clear on a W1C write of 1.
REQ-017 Edge source, simultaneous edge and W1C on the same bit: set SHALL win.
REQ-018 SWTRIG SHALL set PENDING bits of edge sources only; a simultaneous W1C of the same bit SHALL lose to SWTRIG.
REQ-019 Changing EDGE_SEL from 1 to 0 SHALL make the bit follow the level from the next cycle; changing it from 0 to 1 SHALL clear the bit, and the bit SHALL then wait for a new edge.
REQ-020 VECTOR SHALL read bit15 = |ACTIVE and bits3:0 = lowest index set in ACTIVE (0 if none); reads SHALL have no side effects.
REQ-021 irq SHALL be registered as |(PENDING & MASK), asserting one cycle after the ACTIVE bit sets.
REQ-022 Latency SHALL be: irq_in rising before edge k gives PENDING set at edge k+2 and irq high at edge k+3.
REQ-023 An irq_in pulse shorter than one clock period MAY be missed; it SHALL never create more than one pending event.

Reset
REQ-024 On reset_n low, all synchronizer and prev flops, PENDING, MASK, EDGE_SEL, readdata and irq SHALL go to 0 immediately.
REQ-025 A source held high through reset release SHALL NOT register an edge until it goes low and high again; in level mode it SHALL appear pending 2 cycles after release.
REQ-026 Reset mid-operation SHALL discard all pending events.

Structure
REQ-027 Register address constants (ADDR_PENDING..ADDR_SWTRIG) and the N_SRC maximum SHALL live in a shared package.
REQ-028 The lowest-index priority encoder SHALL be one sub-module, irq_prio_enc (N_SRC-wide input, 4-bit index plus valid output).
REQ-029 The synchronizer SHALL be inline; target size is about 150-250 lines.

Verification
REQ-030 Level: MASK=0x01, EDGE_SEL=0, irq_in[0]=1 -> PENDING=0x0001 by edge k+2, irq=1 at k+3; drop input -> irq=0 three cycles later.
REQ-031 Edge plus W1C: EDGE_SEL=0xFF, MASK=0xFF, pulse irq_in[3] for 2 cycles -> PENDING=0x0008 held after the pulse; write 0x0008 to address 0 -> PENDING=0, irq=0 next cycle.
REQ-032 Priority: edges on sources 5 and 2, MASK=0xFF -> VECTOR reads 0x8002; W1C bit 2 -> VECTOR reads 0x8005; W1C bit 5 -> VECTOR reads 0x0000.
REQ-033 Collision: W1C of bit 1 on the same edge that a new bit-1 edge is detected -> PENDING bit 1 remains 1; SWTRIG 0x0010 with EDGE_SEL=0xFF -> PENDING bit 4 set, irq asserts with MASK bit 4 set.
REQ-034 Masking and reset: source pending with MASK=0 -> irq=0 and ACTIVE=0; set MASK -> irq=1 next cycle; assert reset_n mid-operation -> irq, readdata and all registers read 0.
